shift_arbiter: RTL



---
 rtl/shift_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of one shared barrel shifter.
// A single registered valid/ready stage returns results tagged with the requester ID.
module shift_arbiter #(
  parameter  int LENGTH  = 8,
  parameter  int NUM_REQ = 4,
  localparam int SW      = $clog2(LENGTH),
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*LENGTH-1:0] req_data,
  input  logic [NUM_REQ*SW-1:0]     req_shamt,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LENGTH-1:0]         rsp_data,
  output logic [IW-1:0]             rsp_id
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  logic              rsp_valid_q, rsp_valid_d;
  logic [LENGTH-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;
  logic [IW-1:0]     ptr_q, ptr_d;

  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  int                idx;
  logic              can_accept;
  logic              accept;
  logic [LENGTH-1:0] op_data;
  logic [SW-1:0]     op_shamt;
  logic [1:0]        op_code;
  logic [LENGTH-1:0] shf;

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = gnt_found && can_accept && !rst;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // one mux stage per shamt bit; stage k moves by 2^k
  always_comb begin
    op_data  = req_data[int'(gnt_idx)*LENGTH +: LENGTH];
    op_shamt = req_shamt[int'(gnt_idx)*SW +: SW];
    op_code  = req_op[int'(gnt_idx)*2 +: 2];
    shf      = op_data;
    for (int k = 0; k < SW; k++) begin
      if (op_shamt[k]) begin
        unique case (op_code)
          OP_SLL: shf = shf << (1 << k);
          OP_SRL: shf = shf >> (1 << k);
          OP_SRA: shf = $unsigned($signed(shf) >>> (1 << k));
          OP_ROL: shf = (shf << (1 << k))
                      | (shf >> (LENGTH - (1 << k)));
          default: shf = shf;
        endcase
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = shf;
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IW'(NUM_REQ-1)) ? '0
                  : gnt_idx + IW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  a_ready_onehot: assert property (
    @(posedge clk) $onehot0(req_ready));

  a_rsp_stable: assert property (
    @(posedge clk) disable iff (rst)
    rsp_valid_q && !rsp_ready |=>
      rsp_valid_q && $stable(rsp_data_q) && $stable(rsp_id_q));

endmodule
